// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types for the synchronous FWFT FIFO.
//   fifo_op_e - the effective operation performed at a clock edge, after
//               full/empty qualification of the raw enqueue/dequeue requests.
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpEnq  = 2'b01,
        OpDeq  = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    // Pack the qualified enqueue/dequeue strobes into an operation code.
    function automatic fifo_op_e fifo_op(input logic do_enq, input logic do_deq);
        return fifo_op_e'({do_deq, do_enq});
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: plain register array with synchronous write and asynchronous
// read, shaped so that it maps onto distributed RAM. Contents are not reset.
//   clk_i   - clock, write on rising edge
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - read data, combinational from raddr_i
module sync_fifo_mem #(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned BITDEPTH = 2
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [BITDEPTH-1:0] waddr_i,
    input  logic [BITWIDTH-1:0] wdata_i,
    input  logic [BITDEPTH-1:0] raddr_i,
    output logic [BITWIDTH-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << BITDEPTH;

    logic [BITWIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO of 2**BITDEPTH entries.
//   clk6x   - system clock, all state changes on rising edge
//   resetn  - synchronous active-low reset; clears pointers and count
//   wport_i - write data
//   wenq_i  - enqueue request
//   rport_o - head-of-queue data, valid while empty_o=0
//   rdeq_i  - dequeue request
//   full_o  - FIFO holds 2**BITDEPTH entries
//   empty_o - FIFO holds no entries
//   count_o - number of stored entries
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned BITDEPTH = 2
) (
    input  logic                clk6x,
    input  logic                resetn,
    input  logic [BITWIDTH-1:0] wport_i,
    input  logic                wenq_i,
    output logic [BITWIDTH-1:0] rport_o,
    input  logic                rdeq_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [BITDEPTH:0]   count_o
);

    localparam logic [BITDEPTH:0] CountMax = (BITDEPTH + 1)'(1 << BITDEPTH);

    logic [BITDEPTH-1:0] wptr_q, wptr_d;
    logic [BITDEPTH-1:0] rptr_q, rptr_d;
    logic [BITDEPTH:0]   count_q, count_d;
    logic                do_enq, do_deq;
    fifo_op_e            op;

    assign full_o  = (count_q == CountMax);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A dequeue in the same edge frees the head slot, so a full FIFO still
    // accepts the write.
    assign do_enq = wenq_i & (~full_o | rdeq_i);
    assign do_deq = rdeq_i & ~empty_o;
    assign op     = fifo_op(do_enq, do_deq);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_enq) begin
            wptr_d = wptr_q + BITDEPTH'(1);
        end
        if (do_deq) begin
            rptr_d = rptr_q + BITDEPTH'(1);
        end
        unique case (op)
            OpEnq:   count_d = count_q + (BITDEPTH + 1)'(1);
            OpDeq:   count_d = count_q - (BITDEPTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    sync_fifo_mem #(
        .BITWIDTH(BITWIDTH),
        .BITDEPTH(BITDEPTH)
    ) u_mem (
        .clk_i  (clk6x),
        .we_i   (do_enq),
        .waddr_i(wptr_q),
        .wdata_i(wport_i),
        .raddr_i(rptr_q),
        .rdata_o(rport_o)
    );

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    logic       clk6x = 1'b0;
    logic       resetn;
    logic [7:0] wport_i;
    logic       wenq_i;
    logic [7:0] rport_o;
    logic       rdeq_i;
    logic       full_o;
    logic       empty_o;
    logic [2:0] count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    sync_fifo #(
        .BITWIDTH(8),
        .BITDEPTH(2)
    ) dut (
        .clk6x  (clk6x),
        .resetn (resetn),
        .wport_i(wport_i),
        .wenq_i (wenq_i),
        .rport_o(rport_o),
        .rdeq_i (rdeq_i),
        .full_o (full_o),
        .empty_o(empty_o),
        .count_o(count_o)
    );

    always #5 clk6x = ~clk6x;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check status outputs against expected count.
    task automatic check_status(input string tag, input int cnt);
        check({tag, ".count"}, int'(count_o), cnt);
        check({tag, ".empty"}, int'(empty_o), (cnt == 0) ? 1 : 0);
        check({tag, ".full"},  int'(full_o),  (cnt == 4) ? 1 : 0);
    endtask

    // Apply inputs for one edge, then sample 1 time unit after that edge.
    task automatic step(input logic rst_n, input logic enq, input logic [7:0] d,
                        input logic deq);
        resetn  = rst_n;
        wenq_i  = enq;
        wport_i = d;
        rdeq_i  = deq;
        @(posedge clk6x);
        #1;
        resetn  = 1'b1;
        wenq_i  = 1'b0;
        rdeq_i  = 1'b0;
    endtask

    initial begin
        logic [7:0] vals [7];
        vals = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
        resetn  = 1'b0;
        wenq_i  = 1'b0;
        rdeq_i  = 1'b0;
        wport_i = 8'h00;

        // Reset held 4 cycles, then released.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            check_status("reset", 0);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check_status("post_reset", 0);

        // Fill with 12,34,56,78.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, vals[i], 1'b0);
            check_status("fill", i + 1);
            check("fill.head", int'(rport_o), 32'h12);
        end

        // Idle 3 cycles.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            check_status("idle", 4);
            check("idle.head", int'(rport_o), 32'h12);
        end

        // Drain 4.
        for (int i = 0; i < 4; i++) begin
            check("drain.head", int'(rport_o), int'(vals[i]));
            step(1'b1, 1'b0, 8'h00, 1'b1);
            check_status("drain", 3 - i);
        end

        // Enqueue 12,34 then overlap enqueue 56..DE with dequeue.
        step(1'b1, 1'b1, 8'h12, 1'b0);
        check_status("ovl_pre1", 1);
        step(1'b1, 1'b1, 8'h34, 1'b0);
        check_status("ovl_pre2", 2);
        for (int i = 0; i < 5; i++) begin
            check("ovl.head", int'(rport_o), int'(vals[i]));
            step(1'b1, 1'b1, vals[i+2], 1'b1);
            check_status("ovl", 2);
        end
        for (int i = 0; i < 2; i++) begin
            check("ovl_tail.head", int'(rport_o), int'(vals[i+5]));
            step(1'b1, 1'b0, 8'h00, 1'b1);
            check_status("ovl_tail", 1 - i);
        end
        // Dequeue on empty is ignored.
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check_status("deq_empty", 0);

        // Fill, then enqueue+dequeue while full.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, vals[i], 1'b0);
        end
        check_status("full_pre", 4);
        for (int i = 0; i < 3; i++) begin
            check("full_both.head", int'(rport_o), int'(vals[i]));
            step(1'b1, 1'b1, vals[i+4], 1'b1);
            check_status("full_both", 4);
        end
        for (int i = 0; i < 4; i++) begin
            check("full_drain.head", int'(rport_o), int'(vals[i+3]));
            step(1'b1, 1'b0, 8'h00, 1'b1);
            check_status("full_drain", 3 - i);
        end

        // Enqueue while full without dequeue is dropped.
        step(1'b1, 1'b1, 8'h11, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b0);
        step(1'b1, 1'b1, 8'h33, 1'b0);
        step(1'b1, 1'b1, 8'h44, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        check_status("drop", 4);
        check("drop.head", int'(rport_o), 32'h11);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check_status("drop_deq", 3);
        check("drop_deq.head", int'(rport_o), 32'h22);

        // Reset mid-stream wins over a simultaneous enqueue.
        step(1'b0, 1'b1, 8'h66, 1'b1);
        check_status("mid_reset", 0);

        // Enqueue+dequeue on empty: only the enqueue happens, no bypass.
        check_status("no_bypass_pre", 0);
        step(1'b1, 1'b1, 8'h77, 1'b1);
        check_status("no_bypass", 1);
        check("no_bypass.head", int'(rport_o), 32'h77);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check_status("final", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
